// File: rtl/phase_bus_card_responder.sv
// Responder end of the phase bus for one lamp/ADC card.
// Synchronizes the bus pins, decodes reads and writes for the selected card,
// holds the lamp and mux latches, and sequences one ADC settle/convert cycle
// per mux write.
module phase_bus_card_responder #(
   parameter int BOARD_INDEX        = 0,
   parameter int ADC_SETTLE_CYCLES  = 8,
   parameter int ADC_CONVERT_CYCLES = 40
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  board_x,
   input  logic [2:0]  addr_port,
   input  logic        rd_p,
   input  logic        wr_p,
   input  logic        lamp_reset,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic [23:0] lamp_out,
   output logic [2:0]  adc_channel,
   input  logic [15:0] adc_value
);

   localparam int CNT_MAX = (ADC_SETTLE_CYCLES > ADC_CONVERT_CYCLES) ?
                            ADC_SETTLE_CYCLES : ADC_CONVERT_CYCLES;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(ADC_SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] CONV_LAST   = CW'(ADC_CONVERT_CYCLES - 1);
   localparam logic [1:0]    SEL_BIT     = 2'(BOARD_INDEX);

   typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} bus_state_e;
   typedef enum logic [1:0] {A_IDLE, A_SETTLE, A_CONV} adc_state_e;

   // Synchronizer stages: {lamp_reset, rd_p, wr_p, data_in, addr_port, board_x}
   logic [17:0] sync1_q, sync2_q;

   logic [3:0] bx_s;
   logic [2:0] addr_s;
   logic [7:0] din_s;
   logic       wr_s, rd_s, lrst_s, sel;
   logic       unused_bx;

   assign bx_s      = sync2_q[3:0];
   assign addr_s    = sync2_q[6:4];
   assign din_s     = sync2_q[14:7];
   assign wr_s      = sync2_q[15];
   assign rd_s      = sync2_q[16];
   assign lrst_s    = sync2_q[17];
   assign sel       = bx_s[SEL_BIT];
   assign unused_bx = ^bx_s;

   bus_state_e    bus_q, bus_d;
   adc_state_e    adc_q, adc_d;
   logic [2:0]    hold_addr_q, hold_addr_d;
   logic [7:0]    hold_data_q, hold_data_d;
   logic [23:0]   lamp_q, lamp_d;
   logic [2:0]    ch_q, ch_d;
   logic          err_q, err_d;
   logic          rd6_q, rd6_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   result_q, result_d;
   logic          commit3;
   logic          busy;
   logic [7:0]    rd_mux;

   assign busy        = (adc_q != A_IDLE);
   assign lamp_out    = lamp_q;
   assign adc_channel = ch_q;
   assign data_oe     = (bus_q == B_READ);
   assign data_out    = (bus_q == B_READ) ? rd_mux : '0;

   // Two-flop synchronizer for every bus input
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {lamp_reset, rd_p, wr_p, data_in, addr_port, board_x};
         sync2_q <= sync1_q;
      end
   end

   // Read-data mux over the eight ports
   always_comb begin
      rd_mux = '0;
      case (addr_s)
         3'd0:    rd_mux = lamp_q[7:0];
         3'd1:    rd_mux = lamp_q[15:8];
         3'd2:    rd_mux = lamp_q[23:16];
         3'd3:    rd_mux = {5'b0, ch_q};
         3'd4:    rd_mux = result_q[15:8];
         3'd5:    rd_mux = result_q[7:0];
         3'd6:    rd_mux = {busy, err_q, 3'b0, ch_q};
         default: rd_mux = {4'hA, 2'b0, SEL_BIT};
      endcase
   end

   // State register for bus FSM, latches and ADC sequencer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_q       <= B_IDLE;
         adc_q       <= A_IDLE;
         hold_addr_q <= '0;
         hold_data_q <= '0;
         lamp_q      <= '0;
         ch_q        <= '0;
         err_q       <= 1'b0;
         rd6_q       <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
      end else begin
         bus_q       <= bus_d;
         adc_q       <= adc_d;
         hold_addr_q <= hold_addr_d;
         hold_data_q <= hold_data_d;
         lamp_q      <= lamp_d;
         ch_q        <= ch_d;
         err_q       <= err_d;
         rd6_q       <= rd6_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
      end
   end

   // Bus FSM next state: decode, write capture/commit, error tracking
   always_comb begin
      bus_d       = bus_q;
      hold_addr_d = hold_addr_q;
      hold_data_d = hold_data_q;
      lamp_d      = lamp_q;
      ch_d        = ch_q;
      err_d       = err_q;
      rd6_d       = rd6_q;
      commit3     = 1'b0;
      if (lrst_s) begin
         bus_d  = B_IDLE;
         lamp_d = '0;
         ch_d   = '0;
         err_d  = 1'b0;
         rd6_d  = 1'b0;
      end else begin
         case (bus_q)
            B_IDLE: begin
               if (sel && rd_s && wr_s)
                  err_d = 1'b1;
               else if (sel && rd_s)
                  bus_d = B_READ;
               else if (sel && wr_s)
                  bus_d = B_WRITE;
            end
            B_READ: begin
               // A status read clears err only once the read has finished
               if (!rd_s || !sel) begin
                  bus_d = B_IDLE;
                  if (rd6_q || addr_s == 3'd6)
                     err_d = 1'b0;
                  rd6_d = 1'b0;
               end else if (addr_s == 3'd6) begin
                  rd6_d = 1'b1;
               end
            end
            B_WRITE: begin
               if (!wr_s) begin
                  bus_d = B_IDLE;
                  case (hold_addr_q)
                     3'd0: lamp_d[7:0]   = hold_data_q;
                     3'd1: lamp_d[15:8]  = hold_data_q;
                     3'd2: lamp_d[23:16] = hold_data_q;
                     3'd3: begin
                        ch_d    = hold_data_q[2:0];
                        commit3 = 1'b1;
                     end
                     default: ;
                  endcase
               end else if (!sel) begin
                  bus_d = B_IDLE;
               end else begin
                  hold_addr_d = addr_s;
                  hold_data_d = din_s;
               end
            end
            default: bus_d = B_IDLE;
         endcase
      end
   end

   // ADC sequencer next state: settle, convert, latch result
   always_comb begin
      adc_d    = adc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (lrst_s) begin
         adc_d    = A_IDLE;
         cnt_d    = '0;
         result_d = '0;
      end else if (commit3) begin
         adc_d = A_SETTLE;
         cnt_d = '0;
      end else begin
         case (adc_q)
            A_SETTLE: begin
               if (cnt_q == SETTLE_LAST) begin
                  adc_d = A_CONV;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            A_CONV: begin
               if (cnt_q == CONV_LAST) begin
                  adc_d    = A_IDLE;
                  cnt_d    = '0;
                  result_d = adc_value;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               adc_d = A_IDLE;
               cnt_d = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_bus_card_responder.sv
// Four-card rack bench for phase_bus_card_responder with a behavioural register model.
module tb_phase_bus_card_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  board_x;
   logic [2:0]  addr_port;
   logic        rd_p, wr_p, lamp_reset;
   logic [7:0]  data_in;
   logic [15:0] adc_value;

   logic [7:0]  dout  [4];
   logic        doe   [4];
   logic [23:0] lamps [4];
   logic [2:0]  chan  [4];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Card-level model: per-card lamp bytes, channel, result, sticky error
   logic [7:0]  m_lamp   [4][3];
   logic [2:0]  m_ch     [4];
   logic [15:0] m_result [4];
   logic        m_err    [4];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 4; g++) begin : card
      phase_bus_card_responder #(.BOARD_INDEX(g)) u_card (
         .clock(clock), .reset(reset), .board_x(board_x), .addr_port(addr_port),
         .rd_p(rd_p), .wr_p(wr_p), .lamp_reset(lamp_reset), .data_in(data_in),
         .data_out(dout[g]), .data_oe(doe[g]), .lamp_out(lamps[g]),
         .adc_channel(chan[g]), .adc_value(adc_value)
      );
   end

   // Busy-edge monitor on card 2 (cycle numbers counted in rising edges)
   int unsigned cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   logic        busy_prev = 1'b0;
   int unsigned rise_cyc = 0, fall_cyc = 0, n_falls = 0;
   always @(negedge clock) begin
      if (card[2].u_card.busy && !busy_prev) rise_cyc = cyc;
      if (!card[2].u_card.busy && busy_prev) begin
         fall_cyc = cyc;
         n_falls  = n_falls + 1;
      end
      busy_prev = card[2].u_card.busy;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   function automatic int idx_of(input logic [3:0] bx);
      idx_of = 0;
      for (int i = 3; i >= 0; i--) if (bx[i]) idx_of = i;
   endfunction

   function automatic logic [23:0] exp_lamps(input int c);
      exp_lamps = {m_lamp[c][2], m_lamp[c][1], m_lamp[c][0]};
   endfunction

   // Expected register contents with the ADC idle
   function automatic logic [7:0] exp_reg(input int c, input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2: exp_reg = m_lamp[c][a];
         3'd3:    exp_reg = {5'b0, m_ch[c]};
         3'd4:    exp_reg = m_result[c][15:8];
         3'd5:    exp_reg = m_result[c][7:0];
         3'd6:    exp_reg = {1'b0, m_err[c], 3'b0, m_ch[c]};
         default: exp_reg = {4'hA, 2'b0, c[1:0]};
      endcase
   endfunction

   function automatic void model_write(input logic [3:0] bx, input logic [2:0] a, input logic [7:0] d);
      for (int i = 0; i < 4; i++)
         if (bx[i]) begin
            if (a <= 3'd2) m_lamp[i][a] = d;
            else if (a == 3'd3) m_ch[i] = d[2:0];
         end
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 3; j++) m_lamp[i][j] = 8'h00;
         m_ch[i] = 3'd0; m_result[i] = 16'h0000; m_err[i] = 1'b0;
      end
   endfunction

   task automatic bus_read(input logic [3:0] bx, input logic [2:0] a,
                           output logic [7:0] d, output int lat, output int rel);
      int c;
      c = idx_of(bx);
      lat = 0; rel = 0; d = 8'h00;
      @(negedge clock);
      board_x = bx; addr_port = a; rd_p = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (doe[c]) begin lat = k; break; end
      end
      if (lat == 0) begin
         vectors++; miscompares++;
         $display("FAIL read_timeout card %0d port %0d: data_oe never rose, required within 12 clocks", c, a);
      end else begin
         d = dout[c];
      end
      repeat (2) @(negedge clock);
      rd_p = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (!doe[c]) begin rel = k; break; end
      end
      board_x = 4'b0000;
      @(negedge clock);
   endtask

   task automatic bus_write(input logic [3:0] bx, input logic [2:0] a, input logic [7:0] d,
                            output int unsigned drop_cyc);
      @(negedge clock);
      board_x = bx; addr_port = a; data_in = d; wr_p = 1'b1;
      repeat (6) @(negedge clock);
      wr_p = 1'b0;
      drop_cyc = cyc;
      repeat (4) @(negedge clock);
      board_x = 4'b0000;
      model_write(bx, a, d);
   endtask

   task automatic wait_fall(input int unsigned n0);
      for (int k = 0; k < 150; k++) begin
         @(negedge clock);
         if (n_falls != n0) break;
      end
      if (n_falls == n0) begin
         vectors++; miscompares++;
         $display("FAIL busy_timeout: busy never fell within 150 clocks");
      end
   endtask

   task automatic test_reset();
      logic [7:0] d; int lat, rel;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (doe[i] !== 1'b0 || dout[i] !== 8'h00 || lamps[i] !== 24'h0 || chan[i] !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state card %0d: oe=%b out=%h lamps=%h ch=%0d, required 0/00/000000/0",
                     i, doe[i], dout[i], lamps[i], chan[i]);
         end
      end
      bus_read(4'b0100, 3'd7, d, lat, rel);
      vectors++;
      if (d !== 8'hA2) begin miscompares++; $display("FAIL id_card2: got %h, required a2", d); end
      vectors++;
      if (lat != 3) begin miscompares++; $display("FAIL read_latency: got %0d, required 3", lat); end
      vectors++;
      if (rel != 3) begin miscompares++; $display("FAIL release_latency: got %0d, required 3", rel); end
      for (int i = 0; i < 4; i++) begin
         bus_read(4'b0001 << i, 3'd7, d, lat, rel);
         vectors++;
         if (d !== exp_reg(i, 3'd7)) begin
            miscompares++; $display("FAIL id_card%0d: got %h, required %h", i, d, exp_reg(i, 3'd7));
         end
      end
   endtask

   task automatic test_board_select();
      logic [7:0] d; int lat, rel; int unsigned dc;
      bus_write(4'b0001, 3'd1, 8'h5A, dc);
      vectors++;
      if (lamps[0][15:8] !== 8'h5A) begin
         miscompares++; $display("FAIL select_card0: lamps[15:8]=%h, required 5a", lamps[0][15:8]);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (lamps[i] !== exp_lamps(i)) begin
            miscompares++; $display("FAIL select_lamps card %0d: got %h, required %h", i, lamps[i], exp_lamps(i));
         end
      end
      bus_read(4'b0001, 3'd1, d, lat, rel);
      vectors++;
      if (d !== 8'h5A) begin miscompares++; $display("FAIL select_readback: got %h, required 5a", d); end
      bus_read(4'b0010, 3'd1, d, lat, rel);
      vectors++;
      if (d !== 8'h00) begin miscompares++; $display("FAIL select_other: got %h, required 00", d); end
   endtask

   task automatic test_random();
      logic [7:0] d; int lat, rel; int unsigned dc;
      logic [3:0] bx; logic [2:0] a; int c;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            c  = int'($urandom_range(0, 4));
            bx = (c == 4) ? 4'b1111 : (4'b0001 << c);
            a  = 3'($urandom_range(0, 6));
            if (a >= 3'd3) a = a + 3'd1;
            bus_write(bx, a, 8'($urandom), dc);
            for (int i = 0; i < 4; i++) begin
               vectors++;
               if (lamps[i] !== exp_lamps(i)) begin
                  miscompares++;
                  $display("FAIL rand_lamps it %0d card %0d: got %h, required %h", it, i, lamps[i], exp_lamps(i));
               end
            end
         end else begin
            c = int'($urandom_range(0, 3));
            a = 3'($urandom_range(0, 7));
            bus_read(4'b0001 << c, a, d, lat, rel);
            vectors++;
            if (d !== exp_reg(c, a)) begin
               miscompares++;
               $display("FAIL rand_read it %0d card %0d port %0d: got %h, required %h", it, c, a, d, exp_reg(c, a));
            end
            if (a == 3'd6) m_err[c] = 1'b0;
         end
      end
   endtask

   task automatic test_write_latency();
      logic [23:0] old_l;
      old_l = exp_lamps(3);
      @(negedge clock);
      board_x = 4'b1000; addr_port = 3'd2; data_in = 8'hC3; wr_p = 1'b1;
      repeat (6) @(negedge clock);
      wr_p = 1'b0;
      repeat (2) @(negedge clock);
      vectors++;
      if (lamps[3] !== old_l) begin
         miscompares++; $display("FAIL commit_early: lamps=%h after 2 clocks, required %h", lamps[3], old_l);
      end
      model_write(4'b1000, 3'd2, 8'hC3);
      @(negedge clock);
      vectors++;
      if (lamps[3] !== exp_lamps(3)) begin
         miscompares++; $display("FAIL commit_3clk: lamps=%h, required %h", lamps[3], exp_lamps(3));
      end
      repeat (2) @(negedge clock);
      board_x = 4'b0000;
   endtask

   task automatic test_adc();
      logic [7:0] d; int lat, rel; int unsigned dc, n0;
      adc_value = 16'h1234;
      n0 = n_falls;
      bus_write(4'b1111, 3'd3, 8'h05, dc);
      wait_fall(n0);
      vectors++;
      if (rise_cyc - dc != 3) begin
         miscompares++; $display("FAIL busy_start: rose %0d clocks after wr fall, required 3", rise_cyc - dc);
      end
      vectors++;
      if (fall_cyc - rise_cyc != 48) begin
         miscompares++; $display("FAIL busy_width: got %0d, required 48", fall_cyc - rise_cyc);
      end
      for (int i = 0; i < 4; i++) begin
         m_result[i] = 16'h1234;
         vectors++;
         if (chan[i] !== 3'd5) begin miscompares++; $display("FAIL adc_channel card %0d: got %0d, required 5", i, chan[i]); end
         bus_read(4'b0001 << i, 3'd4, d, lat, rel);
         vectors++;
         if (d !== 8'h12) begin miscompares++; $display("FAIL result_hi card %0d: got %h, required 12", i, d); end
         bus_read(4'b0001 << i, 3'd5, d, lat, rel);
         vectors++;
         if (d !== 8'h34) begin miscompares++; $display("FAIL result_lo card %0d: got %h, required 34", i, d); end
      end
   endtask

   task automatic test_restart();
      logic [7:0] d; int lat, rel; int unsigned d1, d2, n0;
      adc_value = 16'h9999;
      n0 = n_falls;
      bus_write(4'b1111, 3'd3, 8'h02, d1);
      repeat (19) @(negedge clock);
      adc_value = 16'h5678;
      bus_write(4'b1111, 3'd3, 8'h06, d2);
      bus_read(4'b0010, 3'd4, d, lat, rel);
      vectors++;
      if (d !== 8'h12) begin miscompares++; $display("FAIL old_result_busy: got %h, required 12", d); end
      wait_fall(n0);
      vectors++;
      if (fall_cyc - (d2 + 3) != 48) begin
         miscompares++; $display("FAIL restart_width: got %0d, required 48", fall_cyc - (d2 + 3));
      end
      repeat (2) @(negedge clock);
      vectors++;
      if (n_falls - n0 != 1) begin
         miscompares++; $display("FAIL restart_single_busy: %0d busy falls, required 1", n_falls - n0);
      end
      for (int i = 0; i < 4; i++) m_result[i] = 16'h5678;
      bus_read(4'b1000, 3'd4, d, lat, rel);
      vectors++;
      if (d !== 8'h56) begin miscompares++; $display("FAIL restart_hi: got %h, required 56", d); end
      bus_read(4'b1000, 3'd5, d, lat, rel);
      vectors++;
      if (d !== 8'h78) begin miscompares++; $display("FAIL restart_lo: got %h, required 78", d); end
      vectors++;
      if (chan[0] !== 3'd6) begin miscompares++; $display("FAIL restart_channel: got %0d, required 6", chan[0]); end
   endtask

   task automatic test_contention();
      logic [7:0] d; int lat, rel; logic drove;
      drove = 1'b0;
      @(negedge clock);
      board_x = 4'b0010; addr_port = 3'd0; data_in = 8'h77; rd_p = 1'b1; wr_p = 1'b1;
      repeat (8) begin @(negedge clock); if (doe[1]) drove = 1'b1; end
      rd_p = 1'b0; wr_p = 1'b0;
      repeat (4) begin @(negedge clock); if (doe[1]) drove = 1'b1; end
      board_x = 4'b0000;
      m_err[1] = 1'b1;
      vectors++;
      if (drove !== 1'b0) begin miscompares++; $display("FAIL contention_drive: data_oe=1 seen, required 0"); end
      vectors++;
      if (lamps[1] !== exp_lamps(1)) begin
         miscompares++; $display("FAIL contention_write: lamps=%h, required %h", lamps[1], exp_lamps(1));
      end
      bus_read(4'b0010, 3'd6, d, lat, rel);
      vectors++;
      if (d !== (8'h40 | {5'b0, m_ch[1]})) begin
         miscompares++; $display("FAIL status_err: got %h, required %h", d, 8'h40 | {5'b0, m_ch[1]});
      end
      m_err[1] = 1'b0;
      bus_read(4'b0010, 3'd6, d, lat, rel);
      vectors++;
      if (d !== exp_reg(1, 3'd6)) begin
         miscompares++; $display("FAIL status_cleared: got %h, required %h", d, exp_reg(1, 3'd6));
      end
      bus_read(4'b0001, 3'd6, d, lat, rel);
      vectors++;
      if (d !== exp_reg(0, 3'd6)) begin
         miscompares++; $display("FAIL status_other_card: got %h, required %h", d, exp_reg(0, 3'd6));
      end
   endtask

   task automatic test_lamp_reset();
      logic [7:0] d; int lat, rel; int unsigned dc, n0; logic up;
      bus_write(4'b0001, 3'd0, 8'hFF, dc);
      adc_value = 16'hBEEF;
      n0 = n_falls;
      bus_write(4'b1111, 3'd3, 8'h01, dc);
      wait_fall(n0);
      bus_read(4'b0001, 3'd4, d, lat, rel);
      vectors++;
      if (d !== 8'hBE) begin miscompares++; $display("FAIL beef_hi: got %h, required be", d); end
      @(negedge clock);
      board_x = 4'b0001; addr_port = 3'd7; rd_p = 1'b1;
      up = 1'b0;
      for (int k = 0; k < 12; k++) begin @(negedge clock); if (doe[0]) begin up = 1'b1; break; end end
      lamp_reset = 1'b1;
      repeat (2) @(negedge clock);
      vectors++;
      if (!up || doe[0] !== 1'b1) begin miscompares++; $display("FAIL lrst_hold: data_oe=%b after 2 clocks, required 1", doe[0]); end
      @(negedge clock);
      vectors++;
      if (doe[0] !== 1'b0) begin miscompares++; $display("FAIL lrst_release: data_oe=%b after 3 clocks, required 0", doe[0]); end
      rd_p = 1'b0; board_x = 4'b0000;
      repeat (2) @(negedge clock);
      lamp_reset = 1'b0;
      repeat (4) @(negedge clock);
      model_clear();
      vectors++;
      if (lamps[0] !== 24'h0 || chan[0] !== 3'd0) begin
         miscompares++; $display("FAIL lrst_outputs: lamps=%h ch=%0d, required 0/0", lamps[0], chan[0]);
      end
      for (int p = 0; p < 6; p++) begin
         bus_read(4'b0001, 3'(p), d, lat, rel);
         vectors++;
         if (d !== 8'h00) begin miscompares++; $display("FAIL lrst_port%0d: got %h, required 00", p, d); end
      end
   endtask

   task automatic test_async_reset();
      logic up;
      up = 1'b0;
      @(negedge clock);
      board_x = 4'b1000; addr_port = 3'd7; rd_p = 1'b1;
      for (int k = 0; k < 12; k++) begin @(negedge clock); if (doe[3]) begin up = 1'b1; break; end end
      vectors++;
      if (!up) begin miscompares++; $display("FAIL areset_setup: data_oe=0, required 1 before reset"); end
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (doe[3] !== 1'b0 || dout[3] !== 8'h00) begin
         miscompares++; $display("FAIL areset_drop: oe=%b out=%h, required 0/00", doe[3], dout[3]);
      end
      @(negedge clock);
      rd_p = 1'b0; board_x = 4'b0000;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; board_x = '0; addr_port = '0; rd_p = 1'b0; wr_p = 1'b0;
      lamp_reset = 1'b0; data_in = '0; adc_value = '0;
      model_clear();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      test_reset();
      test_board_select();
      test_random();
      test_write_latency();
      test_adc();
      test_restart();
      test_contention();
      test_lamp_reset();
      test_async_reset();
      repeat (3) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
